// File: rtl/sort_pkg.sv
// Shared types and helpers for sort_block.
// Define SORTER_SIGNED_EN to compare elements as two's-complement values.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MAX_W = 64;

`ifdef SORTER_SIGNED_EN
  localparam bit SIGNED_CMP = 1'b1;
`else
  localparam bit SIGNED_CMP = 1'b0;
`endif

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Signed order is unsigned order with the element's sign bit inverted.
  function automatic logic elem_gt(input logic [MAX_W-1:0] a,
                                   input logic [MAX_W-1:0] b,
                                   input int               w);
    logic [MAX_W-1:0] mask;
    mask = SIGNED_CMP ? ({{(MAX_W-1){1'b0}}, 1'b1} << (w - 1)) : '0;
    return (a ^ mask) > (b ^ mask);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single combinational compare-swap cell: lo/hi land on the lower/higher index.
// Ordering follows the package compare (SORTER_SIGNED_EN selects signedness).
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descend,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [MAX_W-1:0] w_a_ext;
  logic [MAX_W-1:0] w_b_ext;
  logic             w_swap;

  always_comb begin
    w_a_ext              = '0;
    w_b_ext              = '0;
    w_a_ext[WIDTH-1:0]   = a;
    w_b_ext[WIDTH-1:0]   = b;
    // Strict compare in both directions, so equal values stay put.
    w_swap = descend ? elem_gt(w_b_ext, w_a_ext, WIDTH)
                     : elem_gt(w_a_ext, w_b_ext, WIDTH);
    lo     = w_swap ? b : a;
    hi     = w_swap ? a : b;
  end

endmodule

// File: rtl/sort_block.sv
// Streaming frame sorter: load DEPTH words, odd-even transposition sort
// (one pass per clock), then drain. SORTER_SIGNED_EN selects signed compare.
module sort_block
  import sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             descend,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int             IW   = idx_w(DEPTH);
  localparam int             NE   = DEPTH / 2;
  localparam int             NO   = (DEPTH - 1) / 2;
  localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0]  ONE  = IW'(1);

  state_t           r_state;
  logic [IW-1:0]    r_wr_idx;
  logic [IW-1:0]    r_rd_idx;
  logic [IW-1:0]    r_pass;
  logic             r_desc;
  logic [WIDTH-1:0] r_arr [DEPTH];

  logic [WIDTH-1:0] w_even [DEPTH];
  logic [WIDTH-1:0] w_odd  [DEPTH];
  logic             w_in_fire;
  logic             w_out_fire;

  // Even pass: pairs (0,1),(2,3),...; odd DEPTH leaves the top element alone.
  for (genvar k = 0; k < NE; k++) begin : g_even
    sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .a       (r_arr[2*k]),
      .b       (r_arr[2*k+1]),
      .descend (r_desc),
      .lo      (w_even[2*k]),
      .hi      (w_even[2*k+1])
    );
  end
  if (DEPTH % 2 == 1) begin : g_even_tail
    assign w_even[DEPTH-1] = r_arr[DEPTH-1];
  end

  // Odd pass: pairs (1,2),(3,4),...; element 0 and, for even DEPTH, the top hold.
  for (genvar k = 0; k < NO; k++) begin : g_odd
    sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .a       (r_arr[2*k+1]),
      .b       (r_arr[2*k+2]),
      .descend (r_desc),
      .lo      (w_odd[2*k+1]),
      .hi      (w_odd[2*k+2])
    );
  end
  assign w_odd[0] = r_arr[0];
  if (DEPTH % 2 == 0) begin : g_odd_tail
    assign w_odd[DEPTH-1] = r_arr[DEPTH-1];
  end

  assign in_ready   = (r_state == LOAD) & en & ~rst;
  assign out_valid  = (r_state == DRAIN) & en;
  assign out_data   = r_arr[r_rd_idx];
  assign out_last   = (r_rd_idx == LAST);
  assign busy       = (r_state != LOAD);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_pass   <= '0;
      r_desc   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_arr[i] <= '0;
    end else if (en) begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            r_arr[r_wr_idx] <= in_data;
            // Order is fixed per frame by the first beat.
            if (r_wr_idx == '0) r_desc <= descend;
            if (r_wr_idx == LAST) begin
              r_wr_idx <= '0;
              r_pass   <= '0;
              r_state  <= SORT;
            end else begin
              r_wr_idx <= r_wr_idx + ONE;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++)
            r_arr[i] <= r_pass[0] ? w_odd[i] : w_even[i];
          if (r_pass == LAST) begin
            r_pass   <= '0;
            r_rd_idx <= '0;
            r_state  <= DRAIN;
          end else begin
            r_pass <= r_pass + ONE;
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (r_rd_idx == LAST) begin
              r_rd_idx <= '0;
              r_state  <= LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + ONE;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_block.sv
// Directed scoreboard bench for sort_block (WIDTH=8, DEPTH=8).
// Honours SORTER_SIGNED_EN in its reference ordering.
module tb_sort_block;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst, en, descend, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [$];

  logic [W-1:0] v_mix  [D] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
  logic [W-1:0] v_dup  [D] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hFF};
  logic [W-1:0] v_pair [D] = '{8'd2, 8'd1, 8'd4, 8'd3, 8'd6, 8'd5, 8'd8, 8'd7};
  int lat;

  sort_block #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .descend   (descend),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_gt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORTER_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Insertion sort reference; pushes the expected output order.
  task automatic push_sorted(input logic [W-1:0] v [D], input bit desc);
    logic [W-1:0] s [D];
    logic [W-1:0] key;
    int j;
    s = v;
    for (int i = 1; i < D; i++) begin
      key = s[i];
      j = i - 1;
      while (j >= 0) begin
        if (desc ? ref_gt(key, s[j]) : ref_gt(s[j], key)) begin
          s[j+1] = s[j];
          j--;
        end else break;
      end
      s[j+1] = key;
    end
    for (int i = 0; i < D; i++) exp_q.push_back(s[i]);
  endtask

  task automatic send_frame(input logic [W-1:0] v [D], input bit desc);
    int i = 0;
    int guard = 0;
    while (i < D && guard < 100) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
      descend  = (i == 0) ? desc : ~desc;
      #1;
      if (in_ready) i++;
      guard++;
    end
    if (i != D) chk("load_timeout", i, D);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    descend  = 1'b0;
  endtask

  // Count cycles from the last input beat to the first out_valid.
  task automatic wait_first(input int stall_at, output int l);
    l  = 1;
    en = !(l >= stall_at && l < stall_at + 3);
    #1;
    while (!out_valid && l < 60) begin
      chk("sort_in_ready", in_ready, 1'b0);
      chk("sort_busy", busy, 1'b1);
      @(negedge clk);
      l++;
      en = !(l >= stall_at && l < stall_at + 3);
      #1;
    end
  endtask

  task automatic drain(input bit bp, input int stop);
    int k = 0;
    int got = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [W-1:0] held;
    logic held_last;
    logic [W-1:0] e;
    out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
    #1;
    while (got < stop && guard < 100) begin
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_in_ready", in_ready, 1'b0);
      chk("drain_busy", busy, 1'b1);
      if (stalled) begin
        chk("hold_data", out_data, held);
        chk("hold_last", out_last, held_last);
      end
      if (out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("out_data", out_data, e);
        chk("out_last", out_last, (got == D - 1));
        got++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held      = out_data;
        held_last = out_last;
      end
      if (got < stop) begin
        @(negedge clk);
        k++;
        guard++;
        out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        #1;
      end
    end
    if (got != stop) chk("drain_timeout", got, stop);
    if (stop == D) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("post_busy", busy, 1'b0);
      chk("post_in_ready", in_ready, 1'b1);
      chk("post_out_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; descend = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Ascending, unstalled latency
    push_sorted(v_mix, 1'b0);
    send_frame(v_mix, 1'b0);
    wait_first(100, lat);
    chk("latency_asc", lat, 9);
    drain(1'b0, D);

    // Descending with output backpressure
    push_sorted(v_mix, 1'b1);
    send_frame(v_mix, 1'b1);
    wait_first(100, lat);
    chk("latency_desc", lat, 9);
    drain(1'b1, D);

    // Duplicates and sign-bit handling
    push_sorted(v_dup, 1'b0);
    send_frame(v_dup, 1'b0);
    wait_first(100, lat);
    chk("latency_dup", lat, 9);
    drain(1'b0, D);

    // Enable low for three SORT cycles
    push_sorted(v_mix, 1'b0);
    send_frame(v_mix, 1'b0);
    wait_first(3, lat);
    chk("latency_stall", lat, 12);
    drain(1'b0, D);

    // Reset at the third DRAIN beat
    push_sorted(v_mix, 1'b1);
    send_frame(v_mix, 1'b1);
    wait_first(100, lat);
    drain(1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rec_out_valid", out_valid, 1'b0);
    chk("rec_busy", busy, 1'b0);
    chk("rec_in_ready", in_ready, 1'b1);
    chk("rec_out_data", out_data, 8'h00);
    exp_q.delete();

    push_sorted(v_pair, 1'b0);
    send_frame(v_pair, 1'b0);
    wait_first(100, lat);
    chk("latency_rec", lat, 9);
    drain(1'b0, D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
